// File: rtl/timer1_io_controller.sv
// CPU I/O decode, shared TEMP byte and interrupt arbitration for the Timer1 block.
// Every output is registered; the timer sees write pulses one cycle after the CPU strobe.
module timer1_io_controller #(
  parameter int ADDR_W    = 6,
  parameter int VEC_COMPA = 7,
  parameter int VEC_OVF   = 9
) (
  input  logic              sysClock,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic [7:0]        io_wdata,
  input  logic              io_we,
  input  logic              io_re,
  output logic [7:0]        io_rdata,
  input  logic              sreg_i,
  input  logic              irq_ack,
  output logic              irq_req,
  output logic [4:0]        irq_vector,
  input  logic [7:0]        TCNT1H_output,
  input  logic [7:0]        TCNT1L_output,
  input  logic [7:0]        OCR1AH_output,
  input  logic [7:0]        OCR1AL_output,
  input  logic [7:0]        TCCR_output,
  input  logic [7:0]        TIMSK_output,
  input  logic [7:0]        TIFR_output,
  output logic [7:0]        TCNT1H_input,
  output logic [7:0]        TCNT1L_input,
  output logic [7:0]        OCR1AH_input,
  output logic [7:0]        OCR1AL_input,
  output logic [7:0]        TCCR_input,
  output logic [7:0]        TIMSK_input,
  output logic [7:0]        TIFR_input,
  output logic              TCNT_write_enable,
  output logic              OCR_write_enable,
  output logic              TCCR_write_enable,
  output logic              TIMSK_write_enable,
  output logic              TIFR_write_enable
);

  localparam logic [ADDR_W-1:0] A_OCR1AL = ADDR_W'('h2A);
  localparam logic [ADDR_W-1:0] A_OCR1AH = ADDR_W'('h2B);
  localparam logic [ADDR_W-1:0] A_TCNT1L = ADDR_W'('h2C);
  localparam logic [ADDR_W-1:0] A_TCNT1H = ADDR_W'('h2D);
  localparam logic [ADDR_W-1:0] A_TCCR1  = ADDR_W'('h2E);
  localparam logic [ADDR_W-1:0] A_TIFR   = ADDR_W'('h38);
  localparam logic [ADDR_W-1:0] A_TIMSK  = ADDR_W'('h39);

  localparam logic [7:0] BIT_COMPA = 8'h10;
  localparam logic [7:0] BIT_OVF   = 8'h04;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_CLEAR} state_t;

  state_t     state_q, state_d;
  logic       src_q, src_d;          // 1 = compare-match A, 0 = overflow
  logic       irq_req_q, irq_req_d;
  logic [4:0] irq_vec_q, irq_vec_d;
  logic [7:0] temp_q, temp_d;
  logic [7:0] rdata_q, rdata_d;
  logic [7:0] tcnt_h_q, tcnt_h_d, tcnt_l_q, tcnt_l_d;
  logic [7:0] ocr_h_q, ocr_h_d, ocr_l_q, ocr_l_d;
  logic [7:0] tccr_q, tccr_d, timsk_q, timsk_d, tifr_q, tifr_d;
  logic       tcnt_we_q, tcnt_we_d, ocr_we_q, ocr_we_d, tccr_we_q, tccr_we_d;
  logic       timsk_we_q, timsk_we_d, tifr_we_q, tifr_we_d;

  logic       compa_pend, ovf_pend, src_pend;
  logic       cpu_tifr_wr, fsm_tifr_wr;
  logic [7:0] cpu_tifr_clr, fsm_tifr_clr;

  assign compa_pend = TIFR_output[4] & TIMSK_output[4];
  assign ovf_pend   = TIFR_output[2] & TIMSK_output[2];
  assign src_pend   = src_q ? compa_pend : ovf_pend;

  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    irq_req_d    = irq_req_q;
    irq_vec_d    = irq_vec_q;
    temp_d       = temp_q;
    rdata_d      = rdata_q;
    tcnt_h_d     = tcnt_h_q;
    tcnt_l_d     = tcnt_l_q;
    ocr_h_d      = ocr_h_q;
    ocr_l_d      = ocr_l_q;
    tccr_d       = tccr_q;
    timsk_d      = timsk_q;
    tifr_d       = tifr_q;
    tcnt_we_d    = 1'b0;
    ocr_we_d     = 1'b0;
    tccr_we_d    = 1'b0;
    timsk_we_d   = 1'b0;
    tifr_we_d    = 1'b0;
    cpu_tifr_wr  = 1'b0;
    cpu_tifr_clr = 8'h00;
    fsm_tifr_wr  = 1'b0;
    fsm_tifr_clr = 8'h00;

    if (io_we) begin
      case (io_addr)
        A_TCNT1H, A_OCR1AH: temp_d = io_wdata;
        A_TCNT1L: begin
          tcnt_h_d  = temp_q;
          tcnt_l_d  = io_wdata;
          tcnt_we_d = 1'b1;
        end
        A_OCR1AL: begin
          ocr_h_d  = temp_q;
          ocr_l_d  = io_wdata;
          ocr_we_d = 1'b1;
        end
        A_TCCR1: begin
          tccr_d    = io_wdata;
          tccr_we_d = 1'b1;
        end
        A_TIMSK: begin
          timsk_d    = io_wdata;
          timsk_we_d = 1'b1;
        end
        A_TIFR: begin
          cpu_tifr_wr  = 1'b1;
          cpu_tifr_clr = io_wdata;
        end
        default: ;
      endcase
    end

    // A write wins over a simultaneous read; the read data bus returns zero.
    if (io_we && io_re) begin
      rdata_d = 8'h00;
    end else if (io_re) begin
      case (io_addr)
        A_TCNT1L: begin
          rdata_d = TCNT1L_output;
          temp_d  = TCNT1H_output;
        end
        A_TCNT1H: rdata_d = temp_q;
        A_OCR1AL: rdata_d = OCR1AL_output;
        A_OCR1AH: rdata_d = OCR1AH_output;
        A_TCCR1:  rdata_d = TCCR_output;
        A_TIFR:   rdata_d = TIFR_output;
        A_TIMSK:  rdata_d = TIMSK_output;
        default:  rdata_d = 8'h00;
      endcase
    end

    case (state_q)
      S_IDLE: begin
        // Hold off while a TIFR write is still in flight: TIFR_output is stale
        // until the timer has absorbed it, and would re-raise the cleared source.
        if (sreg_i && (compa_pend || ovf_pend) && !tifr_we_q) begin
          src_d     = compa_pend;
          irq_vec_d = compa_pend ? 5'(VEC_COMPA) : 5'(VEC_OVF);
          irq_req_d = 1'b1;
          state_d   = S_REQ;
        end
      end
      S_REQ: begin
        if (irq_ack) begin
          irq_req_d = 1'b0;
          state_d   = S_CLEAR;
        end else if (!src_pend) begin
          irq_req_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      S_CLEAR: begin
        fsm_tifr_wr  = 1'b1;
        fsm_tifr_clr = src_q ? BIT_COMPA : BIT_OVF;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // CPU and controller clears merge into one write-one-to-clear update.
    if (cpu_tifr_wr || fsm_tifr_wr) begin
      tifr_d    = TIFR_output & ~cpu_tifr_clr & ~fsm_tifr_clr;
      tifr_we_d = 1'b1;
    end
  end

  always_ff @(posedge sysClock or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      src_q      <= 1'b0;
      irq_req_q  <= 1'b0;
      irq_vec_q  <= 5'd0;
      temp_q     <= 8'h00;
      rdata_q    <= 8'h00;
      tcnt_h_q   <= 8'h00;
      tcnt_l_q   <= 8'h00;
      ocr_h_q    <= 8'h00;
      ocr_l_q    <= 8'h00;
      tccr_q     <= 8'h00;
      timsk_q    <= 8'h00;
      tifr_q     <= 8'h00;
      tcnt_we_q  <= 1'b0;
      ocr_we_q   <= 1'b0;
      tccr_we_q  <= 1'b0;
      timsk_we_q <= 1'b0;
      tifr_we_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      irq_req_q  <= irq_req_d;
      irq_vec_q  <= irq_vec_d;
      temp_q     <= temp_d;
      rdata_q    <= rdata_d;
      tcnt_h_q   <= tcnt_h_d;
      tcnt_l_q   <= tcnt_l_d;
      ocr_h_q    <= ocr_h_d;
      ocr_l_q    <= ocr_l_d;
      tccr_q     <= tccr_d;
      timsk_q    <= timsk_d;
      tifr_q     <= tifr_d;
      tcnt_we_q  <= tcnt_we_d;
      ocr_we_q   <= ocr_we_d;
      tccr_we_q  <= tccr_we_d;
      timsk_we_q <= timsk_we_d;
      tifr_we_q  <= tifr_we_d;
    end
  end

  assign io_rdata           = rdata_q;
  assign irq_req            = irq_req_q;
  assign irq_vector         = irq_vec_q;
  assign TCNT1H_input       = tcnt_h_q;
  assign TCNT1L_input       = tcnt_l_q;
  assign OCR1AH_input       = ocr_h_q;
  assign OCR1AL_input       = ocr_l_q;
  assign TCCR_input         = tccr_q;
  assign TIMSK_input        = timsk_q;
  assign TIFR_input         = tifr_q;
  assign TCNT_write_enable  = tcnt_we_q;
  assign OCR_write_enable   = ocr_we_q;
  assign TCCR_write_enable  = tccr_we_q;
  assign TIMSK_write_enable = timsk_we_q;
  assign TIFR_write_enable  = tifr_we_q;

endmodule

// File: tb/tb_timer1_io_controller.sv
// Directed bench for timer1_io_controller: I/O decode, TEMP byte, IRQ handshake, reset.
module tb_timer1_io_controller;

  logic       sysClock = 1'b0;
  logic       rst_n    = 1'b0;
  logic [5:0] io_addr  = '0;
  logic [7:0] io_wdata = '0;
  logic       io_we    = 1'b0;
  logic       io_re    = 1'b0;
  logic       sreg_i   = 1'b0;
  logic       irq_ack  = 1'b0;
  logic [7:0] io_rdata;
  logic       irq_req;
  logic [4:0] irq_vector;

  logic [7:0] tcnt_h = '0, tcnt_l = '0, ocr_h = '0, ocr_l = '0, tccr_o = '0;
  logic [7:0] timsk_o = '0, tifr_o = '0;
  logic       tifr_ld = 1'b0;
  logic [7:0] tifr_ld_val = '0;

  logic [7:0] TCNT1H_input, TCNT1L_input, OCR1AH_input, OCR1AL_input;
  logic [7:0] TCCR_input, TIMSK_input, TIFR_input;
  logic       TCNT_write_enable, OCR_write_enable, TCCR_write_enable;
  logic       TIMSK_write_enable, TIFR_write_enable;
  logic [4:0] ens;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 sysClock = ~sysClock;

  assign ens = {TCNT_write_enable, OCR_write_enable, TCCR_write_enable,
                TIMSK_write_enable, TIFR_write_enable};

  // Stand-in for the timer's TIMSK/TIFR registers; a controller write beats a hardware set.
  always @(posedge sysClock) begin
    if (TIMSK_write_enable) timsk_o <= TIMSK_input;
    if (TIFR_write_enable) tifr_o <= TIFR_input;
    else if (tifr_ld)      tifr_o <= tifr_ld_val;
  end

  timer1_io_controller #(.ADDR_W(6), .VEC_COMPA(7), .VEC_OVF(9)) dut (
    .sysClock(sysClock), .rst_n(rst_n),
    .io_addr(io_addr), .io_wdata(io_wdata), .io_we(io_we), .io_re(io_re),
    .io_rdata(io_rdata), .sreg_i(sreg_i), .irq_ack(irq_ack),
    .irq_req(irq_req), .irq_vector(irq_vector),
    .TCNT1H_output(tcnt_h), .TCNT1L_output(tcnt_l),
    .OCR1AH_output(ocr_h), .OCR1AL_output(ocr_l),
    .TCCR_output(tccr_o), .TIMSK_output(timsk_o), .TIFR_output(tifr_o),
    .TCNT1H_input(TCNT1H_input), .TCNT1L_input(TCNT1L_input),
    .OCR1AH_input(OCR1AH_input), .OCR1AL_input(OCR1AL_input),
    .TCCR_input(TCCR_input), .TIMSK_input(TIMSK_input), .TIFR_input(TIFR_input),
    .TCNT_write_enable(TCNT_write_enable), .OCR_write_enable(OCR_write_enable),
    .TCCR_write_enable(TCCR_write_enable), .TIMSK_write_enable(TIMSK_write_enable),
    .TIFR_write_enable(TIFR_write_enable)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge sysClock);
  endtask

  initial begin
    // Reset state
    repeat (3) cyc();
    chk("rst_irq_req", irq_req, 0);
    chk("rst_vector", irq_vector, 0);
    chk("rst_enables", ens, 0);
    chk("rst_rdata", io_rdata, 0);
    chk("rst_tcnt_h_in", TCNT1H_input, 0);
    rst_n = 1'b1;
    cyc();

    // TEMP-backed 16-bit TCNT1 write
    io_we = 1; io_addr = 6'h2D; io_wdata = 8'h12;
    cyc();
    chk("tcnt_hi_no_pulse", ens, 0);
    io_addr = 6'h2C; io_wdata = 8'h34;
    cyc();
    chk("tcnt_we", TCNT_write_enable, 1);
    chk("tcnt_h_in", TCNT1H_input, 8'h12);
    chk("tcnt_l_in", TCNT1L_input, 8'h34);
    io_we = 0;
    cyc();
    chk("tcnt_we_single", TCNT_write_enable, 0);

    // Atomic TCNT1 read through TEMP
    tcnt_h = 8'hAB; tcnt_l = 8'hCD;
    io_re = 1; io_addr = 6'h2C;
    cyc();
    chk("rd_tcnt_l", io_rdata, 8'hCD);
    io_re = 0; tcnt_h = 8'hAC; tcnt_l = 8'h00;
    cyc();
    chk("rdata_hold", io_rdata, 8'hCD);
    io_re = 1; io_addr = 6'h2D;
    cyc();
    chk("rd_tcnt_h_temp", io_rdata, 8'hAB);
    io_re = 0;

    // OCR1A write via TEMP and direct reads
    io_we = 1; io_addr = 6'h2B; io_wdata = 8'h56;
    cyc();
    io_addr = 6'h2A; io_wdata = 8'h78;
    cyc();
    chk("ocr_we", OCR_write_enable, 1);
    chk("ocr_h_in", OCR1AH_input, 8'h56);
    chk("ocr_l_in", OCR1AL_input, 8'h78);
    io_we = 0; ocr_h = 8'h9E; ocr_l = 8'h3C;
    io_re = 1; io_addr = 6'h2B;
    cyc();
    chk("rd_ocr_h", io_rdata, 8'h9E);
    io_addr = 6'h2A;
    cyc();
    chk("rd_ocr_l", io_rdata, 8'h3C);

    // Unmapped accesses
    io_addr = 6'h10;
    cyc();
    chk("rd_unmapped", io_rdata, 8'h00);
    io_re = 0; io_we = 1; io_wdata = 8'hFF;
    cyc();
    chk("wr_unmapped", ens, 0);
    io_we = 0;

    // Simultaneous write and read
    tccr_o = 8'h5A; io_re = 1; io_addr = 6'h2E;
    cyc();
    chk("rd_tccr", io_rdata, 8'h5A);
    io_we = 1; io_wdata = 8'h05;
    cyc();
    chk("we_re_tccr_we", TCCR_write_enable, 1);
    chk("we_re_tccr_in", TCCR_input, 8'h05);
    chk("we_re_rdata", io_rdata, 8'h00);
    io_re = 0;

    // TIMSK write, flags set, interrupt gated by sreg_i
    io_addr = 6'h39; io_wdata = 8'h14;
    cyc();
    chk("timsk_we", TIMSK_write_enable, 1);
    chk("timsk_in", TIMSK_input, 8'h14);
    io_we = 0; tifr_ld = 1; tifr_ld_val = 8'h14;
    cyc();
    tifr_ld = 0; io_re = 1; io_addr = 6'h38;
    cyc();
    chk("rd_tifr", io_rdata, 8'h14);
    io_re = 0;
    cyc();
    chk("no_irq_sreg_off", irq_req, 0);

    // COMPA wins, then OVF after the CLEAR write lands
    sreg_i = 1;
    cyc();
    chk("irq_compa", irq_req, 1);
    chk("vec_compa", irq_vector, 8'd7);
    sreg_i = 0;
    cyc();
    chk("sreg_drop_holds", irq_req, 1);
    chk("vec_stable", irq_vector, 8'd7);
    irq_ack = 1;
    cyc();
    chk("ack_drops_req", irq_req, 0);
    chk("clear_no_pulse_yet", TIFR_write_enable, 0);
    irq_ack = 0;
    cyc();
    chk("clear_compa_we", TIFR_write_enable, 1);
    chk("clear_compa_in", TIFR_input, 8'h04);
    sreg_i = 1;
    cyc();
    chk("rearb_blocked", irq_req, 0);
    cyc();
    chk("irq_ovf", irq_req, 1);
    chk("vec_ovf", irq_vector, 8'd9);
    irq_ack = 1;
    cyc();
    irq_ack = 0;
    cyc();
    chk("clear_ovf_we", TIFR_write_enable, 1);
    chk("clear_ovf_in", TIFR_input, 8'h00);
    cyc();
    chk("clear_ovf_single", TIFR_write_enable, 0);

    // Request withdrawn when CPU clears the flag before acking
    tifr_ld = 1; tifr_ld_val = 8'h04;
    cyc();
    tifr_ld = 0;
    cyc();
    chk("irq_ovf2", irq_req, 1);
    chk("vec_ovf2", irq_vector, 8'd9);
    io_we = 1; io_addr = 6'h38; io_wdata = 8'h04;
    cyc();
    chk("w1c_we", TIFR_write_enable, 1);
    chk("w1c_in", TIFR_input, 8'h00);
    chk("w1c_req_still", irq_req, 1);
    io_we = 0;
    cyc();
    chk("withdraw_lag", irq_req, 1);
    cyc();
    chk("withdrawn", irq_req, 0);
    irq_ack = 1;
    cyc();
    irq_ack = 0;
    cyc();
    chk("ack_idle_no_we", TIFR_write_enable, 0);
    chk("ack_idle_no_req", irq_req, 0);

    // CPU TIFR write coinciding with CLEAR
    tifr_ld = 1; tifr_ld_val = 8'h14;
    cyc();
    tifr_ld = 0;
    cyc();
    chk("irq_compa2", irq_req, 1);
    chk("vec_compa2", irq_vector, 8'd7);
    irq_ack = 1;
    cyc();
    irq_ack = 0; io_we = 1; io_addr = 6'h38; io_wdata = 8'h04;
    cyc();
    chk("merge_we", TIFR_write_enable, 1);
    chk("merge_in", TIFR_input, 8'h00);
    io_we = 0;
    cyc();
    chk("merge_single", TIFR_write_enable, 0);

    // Asynchronous reset in REQ with a pulse in flight
    io_we = 1; io_addr = 6'h2D; io_wdata = 8'h99;
    cyc();
    io_we = 0; tifr_ld = 1; tifr_ld_val = 8'h14;
    cyc();
    tifr_ld = 0;
    cyc();
    chk("irq_pre_rst", irq_req, 1);
    io_we = 1; io_addr = 6'h2E; io_wdata = 8'h33;
    cyc();
    chk("tccr_pre_rst", TCCR_write_enable, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_req", irq_req, 0);
    chk("async_rst_ens", ens, 0);
    chk("async_rst_vec", irq_vector, 0);
    io_we = 0; sreg_i = 0;
    cyc();
    rst_n = 1'b1;
    io_re = 1; io_addr = 6'h2D;
    cyc();
    chk("temp_cleared", io_rdata, 8'h00);
    io_re = 0;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
